rv32_rf_write_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback stage and a multi-cycle result source such as the divider or a late load return. It also keeps a scoreboard of destinations with a multi-cycle result outstanding, which the hazard unit uses to interlock. The block sits between the WB stage and the register file, and drives the register file's `write_reg` / `sel_d1` / `reg_d1` inputs from registers.

---
 rtl/rv32_pkg.sv | 23 ++
 rtl/rv32_rf_write_arbiter_if.sv | 33 +++
 rtl/rv32_sync_fifo.sv | 57 +++++
 rtl/rv32_rf_write_arbiter.sv | 119 +++++++++++
 tb/tb_rv32_rf_write_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 register-file types: write-port bundle and arbiter grant source.
package rv32_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_FIFO,
    GNT_BYPASS
  } gnt_src_e;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = 1'b1;
  endfunction
endpackage

// File: rtl/rv32_rf_write_arbiter_if.sv
// WB / multi-cycle / issue / register-file-port bundle for the write arbiter.
interface rv32_rf_write_arbiter_if #(
  parameter int unsigned FIFO_DEPTH = 2
);
  import rv32_pkg::*;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  mc_valid;
  logic                  mc_ready;
  logic [REG_ADDR_W-1:0] mc_rd;
  logic [XLEN-1:0]       mc_data;
  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic [NUM_REGS-1:0]   rd_busy;
  logic                  pipe_stall;
  logic [LVL_W-1:0]      fifo_level;
  logic                  write_reg;
  logic [REG_ADDR_W-1:0] sel_d1;
  logic [XLEN-1:0]       reg_d1;

  modport master (
    output wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data, iss_valid, iss_rd,
    input  mc_ready, rd_busy, pipe_stall, fifo_level, write_reg, sel_d1, reg_d1
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, mc_valid, mc_rd, mc_data, iss_valid, iss_rd,
    output mc_ready, rd_busy, pipe_stall, fifo_level, write_reg, sel_d1, reg_d1
  );
endinterface

// File: rtl/rv32_sync_fifo.sv
// Synchronous FIFO of register-file write entries; any depth >= 1.
module rv32_sync_fifo
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  rf_wr_t           din_i,
  output rf_wr_t           head_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  rf_wr_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_i) mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
endmodule

// File: rtl/rv32_rf_write_arbiter.sv
// Register-file write-port arbiter (WB > FIFO head > bypass) with rd scoreboard.
// Define RV32_RFARB_STARVE_EN to compile in the buffered-result starvation counter.
module rv32_rf_write_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  rv32_rf_write_arbiter_if.slave rf
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 1 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("rv32_rf_write_arbiter: FIFO_DEPTH and STARVE_LIMIT must be >= 1");
  end

  gnt_src_e            src;
  rf_wr_t              gnt;
  rf_wr_t              head;
  logic                push, pop, full, empty;
  logic [LVL_W-1:0]    level;
  logic                wb_win, mc_fire, mc_keep, starve_stall;
  logic [NUM_REGS-1:0] busy_q, busy_d, set_mask, clr_mask;
  logic                write_reg_q;
  rf_wr_t              wr_q;

  assign wb_win  = rf.wb_valid && (rf.wb_rd != '0);
  assign mc_fire = rf.mc_valid && rf.mc_ready;
  // rd==0 results complete the handshake but are never buffered or written
  assign mc_keep = mc_fire && (rf.mc_rd != '0);

  always_comb begin
    src  = GNT_NONE;
    gnt  = '0;
    push = 1'b0;
    pop  = 1'b0;
    if (wb_win) begin
      src  = GNT_WB;
      gnt  = '{rd: rf.wb_rd, data: rf.wb_data};
      push = mc_keep;
    end else if (!empty) begin
      src  = GNT_FIFO;
      gnt  = head;
      pop  = 1'b1;
      push = mc_keep;
    end else if (mc_keep) begin
      src  = GNT_BYPASS;
      gnt  = '{rd: rf.mc_rd, data: rf.mc_data};
    end
  end

  rv32_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ('{rd: rf.mc_rd, data: rf.mc_data}),
    .head_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (rf.iss_valid && (rf.iss_rd != '0)) set_mask = rd_onehot(rf.iss_rd);
    if (src == GNT_FIFO || src == GNT_BYPASS) clr_mask = rd_onehot(gnt.rd);
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

`ifdef RV32_RFARB_STARVE_EN
  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (pop)
      starve_d = '0;
    else if (!empty && wb_win && (starve_q != SC_W'(STARVE_LIMIT)))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

  // Saturated count holds until the bubble pops the head; masking with pop keeps the request to one cycle
  assign starve_stall = (starve_q == SC_W'(STARVE_LIMIT)) && !pop;
`else
  assign starve_stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      write_reg_q <= 1'b0;
      wr_q        <= '0;
    end else begin
      busy_q      <= busy_d;
      write_reg_q <= (src != GNT_NONE);
      wr_q        <= gnt;
    end
  end

  assign rf.mc_ready   = !full;
  assign rf.pipe_stall = (full && rf.mc_valid) || starve_stall;
  assign rf.fifo_level = level;
  assign rf.rd_busy    = busy_q;
  assign rf.write_reg  = write_reg_q;
  assign rf.sel_d1     = wr_q.rd;
  assign rf.reg_d1     = wr_q.data;
endmodule

// File: tb/tb_rv32_rf_write_arbiter.sv
// Directed bench for rv32_rf_write_arbiter with FIFO_DEPTH=2, STARVE_LIMIT=4.
module tb_rv32_rf_write_arbiter;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  rv32_rf_write_arbiter_if #(.FIFO_DEPTH(2)) bus ();

  rv32_rf_write_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.mc_valid  = 1'b0;
    bus.mc_rd     = '0;
    bus.mc_data   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = rd;
    step();
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++; if (bus.write_reg !== 1'b0) begin n_mis++; $display("FAIL %s write_reg: got %b want 0", tag, bus.write_reg); end
    n_cmp++; if (bus.sel_d1 !== 5'd0) begin n_mis++; $display("FAIL %s sel_d1: got %0d want 0", tag, bus.sel_d1); end
    n_cmp++; if (bus.reg_d1 !== 32'd0) begin n_mis++; $display("FAIL %s reg_d1: got %h want 0", tag, bus.reg_d1); end
    n_cmp++; if (bus.rd_busy !== 32'd0) begin n_mis++; $display("FAIL %s rd_busy: got %h want 0", tag, bus.rd_busy); end
    n_cmp++; if (bus.fifo_level !== 2'd0) begin n_mis++; $display("FAIL %s fifo_level: got %0d want 0", tag, bus.fifo_level); end
    n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_mis++; $display("FAIL %s pipe_stall: got %b want 0", tag, bus.pipe_stall); end
    n_cmp++; if (bus.mc_ready !== 1'b1) begin n_mis++; $display("FAIL %s mc_ready: got %b want 1", tag, bus.mc_ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    check_reset_values("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_priority();
    issue(5'd7);
    n_cmp++; if (bus.rd_busy !== 32'h0000_0080) begin n_mis++; $display("FAIL prio_busy_set: got %h want 00000080", bus.rd_busy); end
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h0000_AAAA;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd7; bus.mc_data = 32'h0000_1234;
    #1;
    n_cmp++; if (bus.mc_ready !== 1'b1) begin n_mis++; $display("FAIL prio_mc_ready: got %b want 1", bus.mc_ready); end
    step();
    idle();
    n_cmp++; if ({bus.write_reg, bus.sel_d1, bus.reg_d1} !== {1'b1, 5'd5, 32'h0000_AAAA}) begin n_mis++; $display("FAIL prio_wb_write: got %b/%0d/%h want 1/5/0000aaaa", bus.write_reg, bus.sel_d1, bus.reg_d1); end
    n_cmp++; if (bus.fifo_level !== 2'd1) begin n_mis++; $display("FAIL prio_level1: got %0d want 1", bus.fifo_level); end
    n_cmp++; if (bus.rd_busy !== 32'h0000_0080) begin n_mis++; $display("FAIL prio_busy_held: got %h want 00000080", bus.rd_busy); end
    step();
    n_cmp++; if ({bus.write_reg, bus.sel_d1, bus.reg_d1} !== {1'b1, 5'd7, 32'h0000_1234}) begin n_mis++; $display("FAIL prio_mc_write: got %b/%0d/%h want 1/7/00001234", bus.write_reg, bus.sel_d1, bus.reg_d1); end
    n_cmp++; if (bus.rd_busy !== 32'd0) begin n_mis++; $display("FAIL prio_busy_clr: got %h want 0", bus.rd_busy); end
    n_cmp++; if (bus.fifo_level !== 2'd0) begin n_mis++; $display("FAIL prio_level0: got %0d want 0", bus.fifo_level); end
    step();
    n_cmp++; if (bus.write_reg !== 1'b0) begin n_mis++; $display("FAIL prio_idle: got %b want 0", bus.write_reg); end
  endtask

  task automatic test_bypass();
    issue(5'd9);
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd9; bus.mc_data = 32'h0000_DEAD;
    step();
    idle();
    n_cmp++; if ({bus.write_reg, bus.sel_d1, bus.reg_d1} !== {1'b1, 5'd9, 32'h0000_DEAD}) begin n_mis++; $display("FAIL byp_write: got %b/%0d/%h want 1/9/0000dead", bus.write_reg, bus.sel_d1, bus.reg_d1); end
    n_cmp++; if (bus.fifo_level !== 2'd0) begin n_mis++; $display("FAIL byp_level: got %0d want 0", bus.fifo_level); end
    n_cmp++; if (bus.rd_busy !== 32'd0) begin n_mis++; $display("FAIL byp_busy: got %h want 0", bus.rd_busy); end
    step();
  endtask

  task automatic test_full_stall();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h1;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd10; bus.mc_data = 32'hA0;
    step();
    bus.wb_rd = 5'd2; bus.wb_data = 32'h2;
    bus.mc_rd = 5'd11; bus.mc_data = 32'hA1;
    #1;
    n_cmp++; if (bus.mc_ready !== 1'b1) begin n_mis++; $display("FAIL full_ready_l1: got %b want 1", bus.mc_ready); end
    step();
    bus.wb_rd = 5'd3; bus.wb_data = 32'h3;
    bus.mc_rd = 5'd12; bus.mc_data = 32'hA2;
    #1;
    n_cmp++; if (bus.fifo_level !== 2'd2) begin n_mis++; $display("FAIL full_level2: got %0d want 2", bus.fifo_level); end
    n_cmp++; if (bus.mc_ready !== 1'b0) begin n_mis++; $display("FAIL full_ready0: got %b want 0", bus.mc_ready); end
    n_cmp++; if (bus.pipe_stall !== 1'b1) begin n_mis++; $display("FAIL full_stall1: got %b want 1", bus.pipe_stall); end
    step();
    n_cmp++; if ({bus.sel_d1, bus.fifo_level} !== {5'd3, 2'd2}) begin n_mis++; $display("FAIL full_blocked: got sel %0d lvl %0d want sel 3 lvl 2", bus.sel_d1, bus.fifo_level); end
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    step();
    n_cmp++; if ({bus.write_reg, bus.sel_d1, bus.reg_d1} !== {1'b1, 5'd10, 32'hA0}) begin n_mis++; $display("FAIL full_drain_head: got %b/%0d/%h want 1/10/a0", bus.write_reg, bus.sel_d1, bus.reg_d1); end
    n_cmp++; if (bus.mc_ready !== 1'b1) begin n_mis++; $display("FAIL full_ready_back: got %b want 1", bus.mc_ready); end
    n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_mis++; $display("FAIL full_stall_off: got %b want 0", bus.pipe_stall); end
    step();
    bus.mc_valid = 1'b0;
    n_cmp++; if ({bus.sel_d1, bus.reg_d1, bus.fifo_level} !== {5'd11, 32'hA1, 2'd1}) begin n_mis++; $display("FAIL full_pushpop: got sel %0d data %h lvl %0d want 11/a1/1", bus.sel_d1, bus.reg_d1, bus.fifo_level); end
    step();
    idle();
    n_cmp++; if ({bus.write_reg, bus.sel_d1, bus.reg_d1, bus.fifo_level} !== {1'b1, 5'd12, 32'hA2, 2'd0}) begin n_mis++; $display("FAIL full_tail: got %b/%0d/%h lvl %0d want 1/12/a2/0", bus.write_reg, bus.sel_d1, bus.reg_d1, bus.fifo_level); end
    step();
  endtask

  task automatic test_x0();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF;
    step();
    idle();
    n_cmp++; if (bus.write_reg !== 1'b0) begin n_mis++; $display("FAIL x0_wb: got %b want 0", bus.write_reg); end
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd0; bus.mc_data = 32'hBEEF;
    #1;
    n_cmp++; if (bus.mc_ready !== 1'b1) begin n_mis++; $display("FAIL x0_mc_ready: got %b want 1", bus.mc_ready); end
    step();
    n_cmp++; if ({bus.write_reg, bus.fifo_level} !== {1'b0, 2'd0}) begin n_mis++; $display("FAIL x0_mc_bypass: got wr %b lvl %0d want 0/0", bus.write_reg, bus.fifo_level); end
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h44;
    step();
    idle();
    n_cmp++; if ({bus.sel_d1, bus.fifo_level} !== {5'd4, 2'd0}) begin n_mis++; $display("FAIL x0_mc_nopush: got sel %0d lvl %0d want 4/0", bus.sel_d1, bus.fifo_level); end
    issue(5'd0);
    n_cmp++; if (bus.rd_busy !== 32'd0) begin n_mis++; $display("FAIL x0_iss: got %h want 0", bus.rd_busy); end
    step();
  endtask

  task automatic test_set_wins();
    issue(5'd9);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    bus.mc_valid  = 1'b1; bus.mc_rd  = 5'd9; bus.mc_data = 32'h99;
    step();
    idle();
    n_cmp++; if ({bus.write_reg, bus.sel_d1} !== {1'b1, 5'd9}) begin n_mis++; $display("FAIL setclr_write: got %b/%0d want 1/9", bus.write_reg, bus.sel_d1); end
    n_cmp++; if (bus.rd_busy !== 32'h0000_0200) begin n_mis++; $display("FAIL setclr_busy: got %h want 00000200", bus.rd_busy); end
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd9; bus.mc_data = 32'h9A;
    step();
    idle();
    n_cmp++; if (bus.rd_busy !== 32'd0) begin n_mis++; $display("FAIL setclr_final: got %h want 0", bus.rd_busy); end
    step();
  endtask

  task automatic test_starvation();
    issue(5'd20);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h1;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd20; bus.mc_data = 32'h2020;
    step();
    bus.mc_valid = 1'b0; bus.mc_rd = '0; bus.mc_data = '0;
`ifdef RV32_RFARB_STARVE_EN
    for (int i = 0; i < 4; i++) begin
      bus.wb_rd = 5'(2 + i); bus.wb_data = 32'(2 + i);
      #1;
      n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_mis++; $display("FAIL starve_quiet%0d: got %b want 0", i, bus.pipe_stall); end
      step();
    end
    bus.wb_rd = 5'd6; bus.wb_data = 32'h6;
    #1;
    n_cmp++; if (bus.pipe_stall !== 1'b1) begin n_mis++; $display("FAIL starve_pulse: got %b want 1", bus.pipe_stall); end
    step();
`else
    for (int i = 0; i < 6; i++) begin
      bus.wb_rd = 5'(2 + i); bus.wb_data = 32'(2 + i);
      #1;
      n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_mis++; $display("FAIL nostarve_stall%0d: got %b want 0", i, bus.pipe_stall); end
      step();
      n_cmp++; if ({bus.sel_d1, bus.fifo_level} !== {5'(2 + i), 2'd1}) begin n_mis++; $display("FAIL nostarve_wait%0d: got sel %0d lvl %0d want %0d/1", i, bus.sel_d1, bus.fifo_level, 2 + i); end
    end
`endif
    idle();
    #1;
    n_cmp++; if (bus.pipe_stall !== 1'b0) begin n_mis++; $display("FAIL starve_bubble_stall: got %b want 0", bus.pipe_stall); end
    step();
    n_cmp++; if ({bus.write_reg, bus.sel_d1, bus.reg_d1} !== {1'b1, 5'd20, 32'h2020}) begin n_mis++; $display("FAIL starve_drain: got %b/%0d/%h want 1/20/2020", bus.write_reg, bus.sel_d1, bus.reg_d1); end
    n_cmp++; if ({bus.rd_busy, bus.fifo_level} !== {32'd0, 2'd0}) begin n_mis++; $display("FAIL starve_clean: got busy %h lvl %0d want 0/0", bus.rd_busy, bus.fifo_level); end
    step();
  endtask

  task automatic test_reset_mid();
    issue(5'd20);
    issue(5'd21);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h1;
    bus.mc_valid = 1'b1; bus.mc_rd = 5'd20; bus.mc_data = 32'h20;
    step();
    bus.wb_rd = 5'd2; bus.wb_data = 32'h2;
    bus.mc_rd = 5'd21; bus.mc_data = 32'h21;
    step();
    bus.wb_rd = 5'd3; bus.wb_data = 32'h3;
    bus.mc_rd = 5'd22; bus.mc_data = 32'h22;
    #1;
    n_cmp++; if ({bus.fifo_level, bus.pipe_stall, bus.rd_busy} !== {2'd2, 1'b1, 32'h0030_0000}) begin n_mis++; $display("FAIL rstmid_pre: got lvl %0d stall %b busy %h want 2/1/00300000", bus.fifo_level, bus.pipe_stall, bus.rd_busy); end
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("rstmid");
    idle();
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if ({bus.write_reg, bus.fifo_level} !== {1'b0, 2'd0}) begin n_mis++; $display("FAIL rstmid_post: got wr %b lvl %0d want 0/0", bus.write_reg, bus.fifo_level); end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    test_reset();
    test_priority();
    test_bypass();
    test_full_stall();
    test_x0();
    test_set_wins();
    test_starvation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish within 100000 time units want finish");
    $fatal(1, "timeout");
  end
endmodule
